// File: rtl/sha_msg_sched_if.sv
// Handshake/bus bundle for the SHA-256 message-schedule stage.
//   load, block_in : block capture request and 512-bit message block
//   w_out, t_out   : current schedule word W_t and its index t
//   w_valid/w_ready: word handshake toward the compression round stage
//   busy, done     : block in progress / one-cycle end-of-block pulse
// The slave modport is taken by sha_msg_sched; master is the driving side.
interface sha_msg_sched_if;
  logic         load;
  logic [511:0] block_in;
  logic [31:0]  w_out;
  logic [5:0]   t_out;
  logic         w_valid;
  logic         w_ready;
  logic         busy;
  logic         done;

  modport slave (
    input  load, block_in, w_ready,
    output w_out, t_out, w_valid, busy, done
  );

  modport master (
    output load, block_in, w_ready,
    input  w_out, t_out, w_valid, busy, done
  );
endinterface

// File: rtl/sha_msg_sched.sv
// SHA-256 message-schedule stage.
// Captures one 512-bit block on load and emits W0..W(ROUNDS-1), one word per
// accepted w_valid/w_ready handshake. W16 onward are generated in a 16-word
// sliding window; win[0] is always the word being presented.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset (dominates load and handshakes)
//   bus  - sha_msg_sched_if.slave (load, block_in, w_out, t_out, w_valid,
//          w_ready, busy, done)
// Parameter ROUNDS: words per block, 16..64.
// Optional macro SHA_MSG_SCHED_B2B_EN: accept a load in the cycle of the final
// handshake so the next block follows with no bubble.
module sha_msg_sched #(
  parameter int unsigned ROUNDS = 64
) (
  input  logic           clk,
  input  logic           rst,
  sha_msg_sched_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [5:0] LAST = 6'(ROUNDS - 1);

  state_t      state, state_d;
  logic [31:0] win [16];
  logic [5:0]  t;
  logic        done_q;

  logic        hs;
  logic        do_load, do_shift, do_done;
  logic [31:0] w_new;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  assign hs    = (state == RUN) && bus.w_ready;
  assign w_new = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

  always_comb begin
    state_d  = state;
    do_load  = 1'b0;
    do_shift = 1'b0;
    do_done  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.load) begin
          do_load = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (hs) begin
          if (t == LAST) begin
            do_done = 1'b1;
`ifdef SHA_MSG_SCHED_B2B_EN
            if (bus.load) do_load = 1'b1;
            else          state_d = IDLE;
`else
            state_d = IDLE;
`endif
          end else begin
            do_shift = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      t      <= '0;
      done_q <= 1'b0;
      for (int unsigned k = 0; k < 16; k++) win[k] <= '0;
    end else begin
      state  <= state_d;
      done_q <= do_done;
      if (do_load) begin
        for (int unsigned k = 0; k < 16; k++) win[k] <= bus.block_in[511 - 32*k -: 32];
        t <= '0;
      end else if (do_shift) begin
        for (int unsigned k = 0; k < 15; k++) win[k] <= win[k+1];
        win[15] <= w_new;
        t       <= t + 6'd1;
      end
    end
  end

  // The final word is not shifted out, so win[0] keeps it visible in IDLE.
  assign bus.w_out   = win[0];
  assign bus.t_out   = t;
  assign bus.w_valid = (state == RUN);
  assign bus.busy    = (state == RUN);
  assign bus.done    = done_q;

endmodule
